vga_timing_decoder: RTL and testbench

//  Receive side of our 640x480@60 VGA timing: samples hsync/vsync (active-low pulses) on pixel ticks and measures line/frame timing.

---
 rtl/vga_timing_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_vga_timing_decoder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_decoder.sv
// Receive-side VGA timing decoder: measures hsync/vsync timing on pixel ticks,
// locks after consecutive clean frames and regenerates video_on/x/y.
module vga_timing_decoder #(
  parameter int H_RES       = 640,
  parameter int H_PULSE     = 96,
  parameter int H_BACK      = 48,
  parameter int H_FRONT     = 16,
  parameter int V_RES       = 480,
  parameter int V_PULSE     = 2,
  parameter int V_BACK      = 33,
  parameter int V_FRONT     = 10,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       p_tick,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic       locked,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start,
  output logic [7:0] err_count
);

  localparam int H_TOTAL = H_PULSE + H_BACK + H_RES + H_FRONT;
  localparam int V_TOTAL = V_PULSE + V_BACK + V_RES + V_FRONT;
  localparam int GF_W    = $clog2(LOCK_FRAMES + 1);

  localparam logic [9:0] CNT_MAX     = 10'd1023;
  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_PW        = 10'(H_PULSE);
  localparam logic [9:0] V_PW        = 10'(V_PULSE);
  localparam logic [9:0] H_ACT_START = 10'(H_PULSE + H_BACK);
  localparam logic [9:0] H_ACT_END   = 10'(H_PULSE + H_BACK + H_RES);
  localparam logic [9:0] V_ACT_START = 10'(V_PULSE + V_BACK);
  localparam logic [9:0] V_ACT_END   = 10'(V_PULSE + V_BACK + V_RES);
  localparam logic [GF_W-1:0] GF_LAST = GF_W'(LOCK_FRAMES - 1);
  localparam logic [GF_W-1:0] GF_ONE  = GF_W'(1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    if (v == CNT_MAX) return v;
    else return v + 10'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'd255) return v;
    else return v + 8'd1;
  endfunction

  logic            hs_prev_r, vs_prev_r;
  logic [9:0]      h_cnt_r, v_cnt_r, hs_low_r, vs_low_r;
  state_t          state_r, state_s;
  logic [GF_W-1:0] good_frames_r, good_frames_s;
  logic [7:0]      err_count_r, err_count_s;
  logic            hs_fall_s, vs_fall_s, line_ok_s, frame_ok_s, h_sat_s, check_fail_s;
  logic            in_h_s, in_v_s, video_on_s;
  logic [9:0]      x_s, y_s;
  logic            locked_r, video_on_r, frame_start_r;
  logic [9:0]      x_r, y_r;

  // Edge detection and line/frame checks against the previous measurement
  always_comb begin
    hs_fall_s    = p_tick & hs_prev_r & ~hsync_in;
    vs_fall_s    = p_tick & vs_prev_r & ~vsync_in;
    line_ok_s    = (h_cnt_r == H_LAST) && (hs_low_r == H_PW);
    frame_ok_s   = (v_cnt_r == V_LAST) && (vs_low_r == V_PW);
    h_sat_s      = p_tick & (h_cnt_r == CNT_MAX);
    check_fail_s = (hs_fall_s & ~line_ok_s) | (vs_fall_s & ~frame_ok_s) | h_sat_s;
  end

  // Sync history, position counters and pulse-width measurement
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      hs_prev_r <= 1'b1;
      vs_prev_r <= 1'b1;
      h_cnt_r   <= 10'd0;
      v_cnt_r   <= 10'd0;
      hs_low_r  <= 10'd0;
      vs_low_r  <= 10'd0;
    end else if (p_tick) begin
      hs_prev_r <= hsync_in;
      vs_prev_r <= vsync_in;
      if (hs_fall_s) begin
        h_cnt_r  <= 10'd0;
        hs_low_r <= 10'd1;
        v_cnt_r  <= vs_fall_s ? 10'd0 : sat_inc10(v_cnt_r);
      end else begin
        h_cnt_r <= sat_inc10(h_cnt_r);
        if (!hsync_in) hs_low_r <= sat_inc10(hs_low_r);
      end
      // vsync width is measured in lines, so it only advances on hsync edges
      if (vs_fall_s) vs_low_r <= 10'd1;
      else if (hs_fall_s && !vsync_in) vs_low_r <= sat_inc10(vs_low_r);
    end
  end

  // Lock state register, clean-frame counter and error counter
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_r       <= ST_SEARCH;
      good_frames_r <= '0;
      err_count_r   <= 8'd0;
    end else begin
      state_r       <= state_s;
      good_frames_r <= good_frames_s;
      err_count_r   <= err_count_s;
    end
  end

  // Lock next-state: checks are skipped in SEARCH, so the entry edge is never judged
  always_comb begin
    state_s       = state_r;
    good_frames_s = good_frames_r;
    err_count_s   = err_count_r;
    if (p_tick) begin
      case (state_r)
        ST_SEARCH: begin
          if (vs_fall_s) begin
            state_s       = ST_VERIFY;
            good_frames_s = '0;
          end else begin
            state_s = ST_SEARCH;
          end
        end
        ST_VERIFY: begin
          if (check_fail_s) begin
            state_s = ST_SEARCH;
          end else if (vs_fall_s) begin
            good_frames_s = good_frames_r + GF_ONE;
            state_s       = (good_frames_r == GF_LAST) ? ST_LOCKED : ST_VERIFY;
          end else begin
            state_s = ST_VERIFY;
          end
        end
        ST_LOCKED: begin
          if (check_fail_s) begin
            state_s     = ST_SEARCH;
            err_count_s = sat_inc8(err_count_r);
          end else begin
            state_s = ST_LOCKED;
          end
        end
        default: begin
          state_s       = ST_SEARCH;
          good_frames_s = '0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Active-area decode from the registered counters
  always_comb begin
    in_h_s = (h_cnt_r >= H_ACT_START) && (h_cnt_r < H_ACT_END);
    in_v_s = (v_cnt_r >= V_ACT_START) && (v_cnt_r < V_ACT_END);
    if ((state_r == ST_LOCKED) && in_h_s && in_v_s) begin
      video_on_s = 1'b1;
      x_s        = h_cnt_r - H_ACT_START;
      y_s        = v_cnt_r - V_ACT_START;
    end else begin
      video_on_s = 1'b0;
      x_s        = 10'd0;
      y_s        = 10'd0;
    end
  end

  // Output registers, one cycle behind the counters and lock state
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      locked_r      <= 1'b0;
      video_on_r    <= 1'b0;
      x_r           <= 10'd0;
      y_r           <= 10'd0;
      frame_start_r <= 1'b0;
    end else begin
      locked_r      <= (state_r == ST_LOCKED);
      video_on_r    <= video_on_s;
      x_r           <= x_s;
      y_r           <= y_s;
      frame_start_r <= vs_fall_s;
    end
  end

  assign locked      = locked_r;
  assign video_on    = video_on_r;
  assign x           = x_r;
  assign y           = y_r;
  assign frame_start = frame_start_r;
  assign err_count   = err_count_r;

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Scoreboard bench for vga_timing_decoder on a scaled-down timing (25x11) so
// full frames, relock and counter saturation fit in a short run.
module tb_vga_timing_decoder;

  localparam int H_RES = 16, H_PULSE = 4, H_BACK = 3, H_FRONT = 2;
  localparam int V_RES = 6,  V_PULSE = 2, V_BACK = 2, V_FRONT = 1;
  localparam int LOCK_FRAMES = 2;
  localparam int H_TOTAL = H_PULSE + H_BACK + H_RES + H_FRONT;
  localparam int V_TOTAL = V_PULSE + V_BACK + V_RES + V_FRONT;
  localparam int HA0 = H_PULSE + H_BACK;
  localparam int VA0 = V_PULSE + V_BACK;

  logic       clk_100MHz = 1'b0;
  logic       reset, p_tick, hsync_in, vsync_in;
  logic       locked, video_on, frame_start;
  logic [9:0] x, y;
  logic [7:0] err_count;

  vga_timing_decoder #(
    .H_RES(H_RES), .H_PULSE(H_PULSE), .H_BACK(H_BACK), .H_FRONT(H_FRONT),
    .V_RES(V_RES), .V_PULSE(V_PULSE), .V_BACK(V_BACK), .V_FRONT(V_FRONT),
    .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .p_tick(p_tick),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .locked(locked),
    .video_on(video_on), .x(x), .y(y), .frame_start(frame_start),
    .err_count(err_count)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct packed {
    logic       locked;
    logic       video_on;
    logic [9:0] x;
    logic [9:0] y;
    logic       frame_start;
    logic [7:0] err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   tick_div = 1;
  logic noise = 1'b0;

  // Reference model: positions from tick timestamps, unbounded integer counts
  int   m_tick, m_last_hf, m_hs_low, m_lines, m_vs_low, m_mode, m_good, m_err;
  logic m_hs_prev, m_vs_prev;

  task automatic model_reset();
    m_tick = 0; m_last_hf = -1; m_hs_low = 0; m_lines = 0; m_vs_low = 0;
    m_mode = 0; m_good = 0; m_err = 0; m_hs_prev = 1'b1; m_vs_prev = 1'b1;
  endtask

  task automatic model_step(input logic rst, input logic tk, input logic hs,
                            input logic vs, output exp_t e);
    int h, v;
    logic hf, vf, line_good, frame_good, fail;
    h = m_tick - 1 - m_last_hf;
    if (h > 1023) h = 1023;
    v = (m_lines > 1023) ? 1023 : m_lines;
    e = '0;
    e.locked = (m_mode == 2);
    if (m_mode == 2 && h >= HA0 && h < HA0 + H_RES && v >= VA0 && v < VA0 + V_RES) begin
      e.video_on = 1'b1;
      e.x = 10'(h - HA0);
      e.y = 10'(v - VA0);
    end
    if (rst) begin
      e = '0;
      model_reset();
    end else if (tk) begin
      hf = m_hs_prev & ~hs;
      vf = m_vs_prev & ~vs;
      line_good  = (m_tick - m_last_hf == H_TOTAL) && (m_hs_low == H_PULSE);
      frame_good = (m_lines + 1 == V_TOTAL) && (m_vs_low == V_PULSE);
      fail = (hf && !line_good) || (vf && !frame_good) || (h == 1023);
      case (m_mode)
        0: if (vf) begin m_mode = 1; m_good = 0; end
        1: if (fail) m_mode = 0;
           else if (vf) begin
             m_good++;
             if (m_good >= LOCK_FRAMES) m_mode = 2;
           end
        default: if (fail) begin
          m_mode = 0;
          if (m_err < 255) m_err++;
        end
      endcase
      if (hf) begin
        m_last_hf = m_tick;
        m_hs_low  = 1;
        m_lines   = vf ? 0 : m_lines + 1;
      end else if (!hs) begin
        m_hs_low++;
      end
      if (vf) m_vs_low = 1;
      else if (hf && !vs) m_vs_low++;
      m_hs_prev = hs;
      m_vs_prev = vs;
      m_tick++;
      e.frame_start = vf;
    end
    e.err = 8'(m_err);
  endtask

  // Monitor: compare every registered output just after each active edge
  always begin
    @(posedge clk_100MHz);
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if ({locked, video_on, x, y, frame_start, err_count} !== mon_e) begin
        errors++;
        $display("FAIL scoreboard t=%0t got lk=%b vo=%b x=%0d y=%0d fs=%b err=%0d want lk=%b vo=%b x=%0d y=%0d fs=%b err=%0d",
                 $time, locked, video_on, x, y, frame_start, err_count,
                 mon_e.locked, mon_e.video_on, mon_e.x, mon_e.y, mon_e.frame_start, mon_e.err);
      end
    end
  end

  task automatic cyc(input logic rst, input logic tk, input logic hs, input logic vs);
    exp_t e;
    @(negedge clk_100MHz);
    reset = rst; p_tick = tk; hsync_in = hs; vsync_in = vs;
    model_step(rst, tk, hs, vs, e);
    exp_q.push_back(e);
  endtask

  task automatic pixel(input logic hs, input logic vs);
    for (int i = 1; i < tick_div; i++)
      cyc(1'b0, 1'b0, noise ? 1'($urandom_range(0, 1)) : hs,
                      noise ? 1'($urandom_range(0, 1)) : vs);
    cyc(1'b0, 1'b1, hs, vs);
  endtask

  task automatic line(input logic vs, input int len, input int pw);
    for (int i = 0; i < len; i++) pixel((i < pw) ? 1'b0 : 1'b1, vs);
  endtask

  task automatic frame(input int vpw, input int bad_line, input int bad_len, input int bad_pw);
    for (int l = 0; l < V_TOTAL; l++)
      line((l < vpw) ? 1'b0 : 1'b1, (l == bad_line) ? bad_len : H_TOTAL,
           (l == bad_line) ? bad_pw : H_PULSE);
  endtask

  task automatic clean_frame();
    frame(V_PULSE, -1, 0, 0);
  endtask

  task automatic settle();
    @(posedge clk_100MHz);
    #2;
  endtask

  task automatic dchk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  initial begin
    int kind, bl;
    reset = 1'b1; p_tick = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    model_reset();
    repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b1);
    settle();
    dchk("reset_locked", int'(locked), 0);
    dchk("reset_err", int'(err_count), 0);
    dchk("reset_video_on", int'(video_on), 0);

    // Clean stream at full pixel rate: locks on the third frame edge
    repeat ($urandom_range(3, 40)) pixel(1'b1, 1'b1);
    repeat (3) clean_frame();
    settle();
    dchk("lock_clean", int'(locked), 1);
    dchk("lock_clean_err", int'(err_count), 0);
    clean_frame();

    // One short line while locked
    frame(V_PULSE, 3, H_TOTAL - 1, H_PULSE);
    settle();
    dchk("short_line_unlock", int'(locked), 0);
    dchk("short_line_err", int'(err_count), 1);
    repeat (3) clean_frame();
    settle();
    dchk("relock", int'(locked), 1);
    dchk("relock_err", int'(err_count), 1);

    // hsync stuck high while locked, then a 3-line vsync pulse during VERIFY
    repeat (1100) pixel(1'b1, 1'b1);
    settle();
    dchk("stuck_unlock", int'(locked), 0);
    dchk("stuck_err", int'(err_count), 2);
    clean_frame();
    frame(3, -1, 0, 0);
    clean_frame();
    settle();
    dchk("wide_vs_unlocked", int'(locked), 0);
    dchk("wide_vs_err", int'(err_count), 2);

    // Relock, then reset inside the active area
    repeat (3) clean_frame();
    repeat (2) line(1'b0, H_TOTAL, H_PULSE);
    repeat (3) line(1'b1, H_TOTAL, H_PULSE);
    repeat (H_PULSE) pixel(1'b0, 1'b1);
    repeat (6) pixel(1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    settle();
    dchk("midreset_locked", int'(locked), 0);
    dchk("midreset_video_on", int'(video_on), 0);
    dchk("midreset_x", int'(x), 0);
    dchk("midreset_y", int'(y), 0);
    dchk("midreset_err", int'(err_count), 0);

    // Quarter-rate ticks with sync noise on the idle cycles
    tick_div = 4;
    noise = 1'b1;
    repeat (3) clean_frame();
    settle();
    dchk("slow_lock", int'(locked), 1);
    dchk("slow_err", int'(err_count), 0);
    noise = 1'b0;

    // Random rates and random single timing faults
    repeat (8) begin
      tick_div = $urandom_range(1, 3);
      noise = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 3);
      bl = $urandom_range(0, V_TOTAL - 1);
      case (kind)
        1: frame(V_PULSE, bl, ($urandom_range(0, 1) == 0) ? H_TOTAL - 1 : H_TOTAL + 1, H_PULSE);
        2: frame(V_PULSE, bl, H_TOTAL, ($urandom_range(0, 1) == 0) ? H_PULSE - 1 : H_PULSE + 1);
        3: frame(($urandom_range(0, 1) == 0) ? V_PULSE - 1 : V_PULSE + 1, -1, 0, 0);
        default: clean_frame();
      endcase
    end

    tick_div = 1;
    noise = 1'b0;
    repeat (5) cyc(1'b0, 1'b0, 1'b1, 1'b1);
    settle();
    dchk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
